// File: rtl/spi_arbiter_pkg.sv
// spi_arbiter_pkg
//   Shared types and defaults for the two-requester SPI burst arbiter.
//   state_t        : burst sequencer states
//   *_DEF          : default CS setup/hold gaps and busy watchdog limit
//   LEN_W          : width of the remaining-byte counter (holds 1..256)
//   len_to_count() : maps a burst length byte to a byte count (0 -> 256)
//   owner_onehot() : one-hot per-requester vector for a 1-bit owner index
package spi_arbiter_pkg;

    localparam int LEN_W              = 9;
    localparam int CS_SETUP_DEF       = 2;
    localparam int CS_HOLD_DEF        = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    function automatic logic [LEN_W-1:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? LEN_W'(256) : {1'b0, len};
    endfunction

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if
//   Connection between the arbiter and the shared SPI engine.
//   spi_start   : arbiter -> engine, start the next byte
//   spi_data_tx : arbiter -> engine, byte to shift out
//   spi_divisor : arbiter -> engine, clock divisor of the current owner
//   spi_busy    : engine -> arbiter, byte transfer in progress
//   spi_data_rx : engine -> arbiter, byte shifted in
//   Modports: master (arbiter side), slave (engine side).
interface spi_arbiter_if;

    logic       spi_start;
    logic [7:0] spi_data_tx;
    logic [2:0] spi_divisor;
    logic       spi_busy;
    logic [7:0] spi_data_rx;

    modport master (
        output spi_start,
        output spi_data_tx,
        output spi_divisor,
        input  spi_busy,
        input  spi_data_rx
    );

    modport slave (
        input  spi_start,
        input  spi_data_tx,
        input  spi_divisor,
        output spi_busy,
        output spi_data_rx
    );

endinterface

// File: rtl/spi_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Combinational 2-way round-robin pick.
//   req_i  [1:0] : request levels
//   last_i       : index of the requester granted most recently
//   gnt_o  [1:0] : one-hot grant, 00 when nothing is requested
//   On a tie the requester that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one SPI engine between two requesters with round-robin
//   arbitration and runs a multi-byte burst per grant: per-requester chip
//   select with setup/hold gaps, byte-by-byte start/busy handshake with the
//   engine, divisor and data muxing.
//
//   Optional feature macro: SPI_ARB_TIMEOUT_EN
//     defined   : busy-assert watchdog in WAIT_BUSY (TIMEOUT_CYCLES), error pulses
//     undefined : WAIT_BUSY waits forever, error tied to 00, no counter
//
//   Ports
//     raw_clk, reset        : clock, synchronous active-high reset
//     req[1:0]              : request levels
//     len0/len1             : burst byte count per requester (0 = 256)
//     div0/div1             : SPI divisor per requester
//     tx_byte0/tx_byte1     : next byte to send per requester
//     tx_take[1:0]          : pulse when tx_byteN has been consumed
//     rx_byte, rx_valid[1:0]: last received byte and per-requester valid pulse
//     grant[1:0]            : one-hot current owner
//     done[1:0], error[1:0] : burst-complete and timeout pulses
//     cs_n[1:0]             : active-low chip selects
//     spi                   : engine connection (spi_arbiter_if.master)
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | no owner; grant when a request is up and the engine is idle
//   SETUP     | CS low, counting the setup gap before the first byte
//   START     | capture tx byte, raise spi_start, pulse tx_take
//   WAIT_BUSY | spi_start held until the engine reports busy
//   WAIT_DONE | waiting for busy to fall; capture rx byte
//   HOLD      | CS still low for the hold gap, then release and pulse done
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    input  logic [2:0]  div0,
    input  logic [2:0]  div1,
    input  logic [7:0]  tx_byte0,
    input  logic [7:0]  tx_byte1,
    output logic [1:0]  tx_take,
    output logic [7:0]  rx_byte,
    output logic [1:0]  rx_valid,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  error,
    output logic [1:0]  cs_n,
    spi_arbiter_if.master spi
);

    localparam int CNT_W = 8;
    // SETUP lasts CS_SETUP cycles; HOLD lasts CS_HOLD+1 so that CS rises
    // CS_HOLD+1 cycles after the last rx_valid (which shares HOLD's first cycle).
    localparam logic [CNT_W-1:0] SETUP_LOAD = (CS_SETUP > 0) ? CNT_W'(CS_SETUP - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       cs_n_q, cs_n_d;
    logic             start_q, start_d;
    logic [7:0]       data_tx_q, data_tx_d;
    logic [2:0]       div_q, div_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [1:0]       rx_valid_q, rx_valid_d;
    logic [1:0]       tx_take_q, tx_take_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       arb_gnt;
    logic [1:0]       owner_oh;

`ifdef SPI_ARB_TIMEOUT_EN
    // Down-counter loaded in START; spi_start stays up TIMEOUT_CYCLES cycles max.
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  error_q, error_d;
`endif

    rr_arbiter2 u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    assign owner_oh = owner_onehot(owner_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        cs_n_d     = cs_n_q;
        start_d    = start_q;
        data_tx_d  = data_tx_q;
        div_d      = (grant_q != 2'b00) ? (owner_q ? div1 : div0) : div_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 2'b00;
        tx_take_d  = 2'b00;
        done_d     = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
        error_d    = 2'b00;
`endif

        case (state_q)
            ST_IDLE: begin
                // A still-busy engine (e.g. after a mid-burst reset) blocks new grants.
                if (req != 2'b00 && !spi.spi_busy) begin
                    owner_d = arb_gnt[1];
                    rem_d   = len_to_count(arb_gnt[1] ? len1 : len0);
                    grant_d = arb_gnt;
                    cs_n_d  = ~arb_gnt;
                    div_d   = arb_gnt[1] ? div1 : div0;
                    cnt_d   = SETUP_LOAD;
                    state_d = (CS_SETUP > 0) ? ST_SETUP : ST_START;
                end
            end

            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_START: begin
                data_tx_d = owner_q ? tx_byte1 : tx_byte0;
                start_d   = 1'b1;
                tx_take_d = owner_oh;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_d     = TMO_LOAD;
`endif
                state_d   = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (spi.spi_busy) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == 16'd0) begin
                    start_d = 1'b0;
                    error_d = owner_oh;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
`endif
            end

            ST_WAIT_DONE: begin
                if (!spi.spi_busy) begin
                    rx_byte_d  = spi.spi_data_rx;
                    rx_valid_d = owner_oh;
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    if (rem_q <= LEN_W'(1)) begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 2'b11;
                    done_d  = owner_oh;
                    grant_d = 2'b00;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                cs_n_d  = 2'b11;
                grant_d = 2'b00;
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rem_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            cs_n_q     <= 2'b11;
            start_q    <= 1'b0;
            data_tx_q  <= 8'h00;
            div_q      <= 3'd0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 2'b00;
            tx_take_q  <= 2'b00;
            done_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            cs_n_q     <= cs_n_d;
            start_q    <= start_d;
            data_tx_q  <= data_tx_d;
            div_q      <= div_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            tx_take_q  <= tx_take_d;
            done_q     <= done_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tmo_q   <= 16'd0;
            error_q <= 2'b00;
        end else begin
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 2'b00;
`endif

    assign grant           = grant_q;
    assign cs_n            = cs_n_q;
    assign tx_take         = tx_take_q;
    assign rx_byte         = rx_byte_q;
    assign rx_valid        = rx_valid_q;
    assign done            = done_q;
    assign spi.spi_start   = start_q;
    assign spi.spi_data_tx = data_tx_q;
    assign spi.spi_divisor = div_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
    import spi_arbiter_pkg::*;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TMO      = 8;

    logic       raw_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] req     = 2'b00;
    logic [7:0] len0    = 8'd1;
    logic [7:0] len1    = 8'd1;
    logic [2:0] div0    = 3'd0;
    logic [2:0] div1    = 3'd0;
    logic [7:0] tx_byte0 = 8'hA1;
    logic [7:0] tx_byte1 = 8'h51;
    logic [1:0] tx_take, rx_valid, grant, done, error, cs_n;
    logic [7:0] rx_byte;

    // engine model state
    logic       eng_busy  = 1'b0;
    logic [7:0] eng_rx    = 8'h00;
    int         eng_cnt   = 0;
    bit         eng_stick = 1'b0;
    bit         eng_dead  = 1'b0;

    spi_arbiter_if spi ();
    assign spi.spi_busy    = eng_busy;
    assign spi.spi_data_rx = eng_rx;

    spi_arbiter #(
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
`ifdef SPI_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .raw_clk  (raw_clk),
        .reset    (reset),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .div0     (div0),
        .div1     (div1),
        .tx_byte0 (tx_byte0),
        .tx_byte1 (tx_byte1),
        .tx_take  (tx_take),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .grant    (grant),
        .done     (done),
        .error    (error),
        .cs_n     (cs_n),
        .spi      (spi)
    );

    always #5 raw_clk = ~raw_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge raw_clk);
            #1;
        end
    endtask

    // Engine: busy rises the cycle it sees spi_start, stays 3 cycles, loops tx back to rx.
    always @(negedge raw_clk) begin
        if (eng_dead) begin
            eng_busy = 1'b0;
        end else if (!eng_busy) begin
            if (spi.spi_start) begin
                eng_busy = 1'b1;
                eng_cnt  = 3;
                eng_rx   = spi.spi_data_tx;
            end
        end else if (!eng_stick) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_busy = 1'b0;
        end
    end

    // Requesters: byte stream base+k, advanced on each tx_take.
    logic [7:0] base_b [2];
    int take_idx [2];
    int rx_idx [2];
    initial begin
        base_b[0] = 8'hA1;
        base_b[1] = 8'h51;
        take_idx[0] = 0; take_idx[1] = 0;
        rx_idx[0] = 0;   rx_idx[1] = 0;
    end

    always @(negedge raw_clk) begin
        if (tx_take[0] === 1'b1) take_idx[0]++;
        if (tx_take[1] === 1'b1) take_idx[1]++;
        tx_byte0 = 8'(base_b[0] + 8'(take_idx[0]));
        tx_byte1 = 8'(base_b[1] + 8'(take_idx[1]));
    end

    // Monitor
    bit mon_en = 1'b0;
    int cyc = 0, last_rx_cyc = 0, burst_starts = 0;
    int n_take [2];
    int n_rx [2];
    int n_done [2];
    int viol_cs = 0, viol_div = 0, viol_gap = 0, viol_take = 0, viol_own = 0, viol_err = 0;
    logic prev_start = 1'b0;

    always @(negedge raw_clk) begin
        cyc++;
        if (mon_en) begin
            for (int r = 0; r < 2; r++) begin
                if (tx_take[r]) n_take[r]++;
                if (rx_valid[r]) begin
                    n_rx[r]++;
                    check($sformatf("rx_data%0d", r), {24'h0, rx_byte},
                          {24'h0, 8'(base_b[r] + 8'(rx_idx[r]))});
                    rx_idx[r]++;
                    last_rx_cyc = cyc;
                end
                if (done[r]) n_done[r]++;
            end
            if (cs_n == 2'b00 || cs_n !== ~grant) viol_cs++;
            if (grant == 2'b01 && spi.spi_divisor !== div0) viol_div++;
            if (grant == 2'b10 && spi.spi_divisor !== div1) viol_div++;
            if (((rx_valid | tx_take) & ~grant) != 2'b00) viol_own++;
            if (spi.spi_start && !prev_start) begin
                if (tx_take !== grant) viol_take++;
                if (burst_starts > 0 && cyc != last_rx_cyc + 1) viol_gap++;
                burst_starts++;
            end
            if (grant == 2'b00) burst_starts = 0;
`ifndef SPI_ARB_TIMEOUT_EN
            if (error !== 2'b00) viol_err++;
`endif
        end
        prev_start = spi.spi_start;
    end

    typedef struct packed {
        logic [1:0] req;
        logic [7:0] len0;
        logic [7:0] len1;
        logic [2:0] div0;
        logic [2:0] div1;
        logic [1:0] exp_grant;
        logic [9:0] exp_n;
        logic [2:0] exp_div;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int k;
        int o;
        logic [1:0] exp_g;
        int viol_busy;

        // req, len0, len1, div0, div1, exp_grant, exp_n, exp_div  (last starts at 1)
        vecs[0] = '{2'b01, 8'd3, 8'd1, 3'd2, 3'd5, 2'b01, 10'd3,   3'd2};
        vecs[1] = '{2'b10, 8'd3, 8'd2, 3'd2, 3'd5, 2'b10, 10'd2,   3'd5};
        vecs[2] = '{2'b11, 8'd1, 8'd4, 3'd3, 3'd6, 2'b01, 10'd1,   3'd3};
        vecs[3] = '{2'b11, 8'd2, 8'd1, 3'd3, 3'd6, 2'b10, 10'd1,   3'd6};
        vecs[4] = '{2'b10, 8'd7, 8'd5, 3'd1, 3'd7, 2'b10, 10'd5,   3'd7};
        vecs[5] = '{2'b11, 8'd2, 8'd9, 3'd4, 3'd0, 2'b01, 10'd2,   3'd4};
        vecs[6] = '{2'b01, 8'd0, 8'd3, 3'd2, 3'd5, 2'b01, 10'd256, 3'd2};
        vecs[7] = '{2'b11, 8'd1, 8'd0, 3'd1, 3'd3, 2'b10, 10'd256, 3'd3};

        for (int r = 0; r < 2; r++) begin n_take[r] = 0; n_rx[r] = 0; n_done[r] = 0; end

        // Reset values
        reset = 1'b1;
        step(3);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_cs_n", {30'h0, cs_n}, 32'h3);
        reset = 1'b0;
        step(1);
        mon_en = 1'b1;
        check("rst_spi_start", {31'h0, spi.spi_start}, 32'h0);
        check("rst_data_tx", {24'h0, spi.spi_data_tx}, 32'h0);
        check("rst_divisor", {29'h0, spi.spi_divisor}, 32'h0);
        check("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
        check("rst_pulses", {22'h0, rx_valid, tx_take, done, error, cs_n}, 32'h3);

        // Table-driven bursts
        for (int i = 0; i < 8; i++) begin
            o = vecs[i].exp_grant[1] ? 1 : 0;
            len0 = vecs[i].len0; len1 = vecs[i].len1;
            div0 = vecs[i].div0; div1 = vecs[i].div1;
            for (int r = 0; r < 2; r++) begin n_take[r] = 0; n_rx[r] = 0; n_done[r] = 0; end
            req = vecs[i].req;
            step(1);
            check($sformatf("v%0d_grant", i), {30'h0, grant}, {30'h0, vecs[i].exp_grant});
            check($sformatf("v%0d_cs_n", i), {30'h0, cs_n}, {30'h0, ~vecs[i].exp_grant});
            req = 2'b00;
            step(CS_SETUP);
            check($sformatf("v%0d_start_early", i), {31'h0, spi.spi_start}, 32'h0);
            step(1);
            check($sformatf("v%0d_start_lat", i), {31'h0, spi.spi_start}, 32'h1);
            k = 0;
            while (done == 2'b00 && k < 4000) begin step(1); k++; end
            check($sformatf("v%0d_done", i), {30'h0, done}, {30'h0, vecs[i].exp_grant});
            check($sformatf("v%0d_cs_release", i), {28'h0, cs_n, grant}, 32'hC);
            check($sformatf("v%0d_divisor", i), {29'h0, spi.spi_divisor}, {29'h0, vecs[i].exp_div});
            check($sformatf("v%0d_n_rx", i), n_rx[o], {22'h0, vecs[i].exp_n});
            check($sformatf("v%0d_n_take", i), n_take[o], {22'h0, vecs[i].exp_n});
            check($sformatf("v%0d_other_idle", i), n_rx[1-o] + n_take[1-o], 0);
            check($sformatf("v%0d_hold_lat", i), cyc - last_rx_cyc, CS_HOLD + 1);
            step(1);
            check($sformatf("v%0d_done_pulse", i), {30'h0, done}, 32'h0);
            check($sformatf("v%0d_done_count", i), n_done[o] + n_done[1-o], 1);
        end

        // Contention: req=11 held, len=1; last owner was requester 1.
        len0 = 8'd1; len1 = 8'd1; div0 = 3'd2; div1 = 3'd5;
        exp_g = 2'b01;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (grant == 2'b00 && k < 50) begin step(1); k++; end
            if (g == 3) req = 2'b00;
            check($sformatf("rr_grant%0d", g), {30'h0, grant}, {30'h0, exp_g});
            check($sformatf("rr_div%0d", g), {29'h0, spi.spi_divisor}, exp_g[1] ? 32'd5 : 32'd2);
            k = 0;
            while (grant != 2'b00 && k < 100) begin step(1); k++; end
            check($sformatf("rr_release%0d", g), {30'h0, grant}, 32'h0);
            exp_g = ~exp_g;
        end
        step(5);
        check("rr_no_extra_grant", {30'h0, grant}, 32'h0);

        // Reset in WAIT_DONE with engine still busy
        len0 = 8'd2;
        eng_stick = 1'b1;
        req = 2'b01;
        step(1);
        req = 2'b00;
        k = 0;
        while (!(eng_busy && !spi.spi_start && grant != 2'b00) && k < 50) begin step(1); k++; end
        check("rst_mid_in_wait_done", {31'h0, eng_busy}, 32'h1);
        for (int r = 0; r < 2; r++) begin n_done[r] = 0; n_rx[r] = 0; end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_mid_cs_n", {30'h0, cs_n}, 32'h3);
        check("rst_mid_grant", {30'h0, grant}, 32'h0);
        rx_idx[0] = take_idx[0];
        req = 2'b01;
        viol_busy = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (grant != 2'b00) viol_busy++;
        end
        check("rst_mid_no_grant_busy", viol_busy, 0);
        check("rst_mid_no_done", n_done[0] + n_done[1], 0);
        eng_stick = 1'b0;
        k = 0;
        while (grant == 2'b00 && k < 20) begin step(1); k++; end
        req = 2'b00;
        check("rst_mid_regrant", {30'h0, grant}, 32'h1);
        check("rst_mid_regrant_idle", {31'h0, eng_busy}, 32'h0);
        k = 0;
        while (done == 2'b00 && k < 200) begin step(1); k++; end
        check("rst_mid_done", {30'h0, done}, 32'h1);
        check("rst_mid_n_rx", n_rx[0], 2);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: engine never raises busy.
        eng_dead = 1'b1;
        len0 = 8'd3;
        req = 2'b01;
        step(1);
        req = 2'b00;
        check("tmo_grant", {30'h0, grant}, 32'h1);
        k = 0;
        while (!spi.spi_start && k < 20) begin step(1); k++; end
        k = 0;
        while (spi.spi_start && k < 50) begin step(1); k++; end
        check("tmo_start_cycles", k, TMO);
        check("tmo_error", {30'h0, error}, 32'h1);
        step(CS_HOLD);
        check("tmo_done_early", {30'h0, done}, 32'h0);
        step(1);
        check("tmo_done", {30'h0, done}, 32'h1);
        check("tmo_cs_release", {30'h0, cs_n}, 32'h3);
        eng_dead = 1'b0;
        step(2);
`endif

        check("inv_cs_exclusive", viol_cs, 0);
        check("inv_divisor_mux", viol_div, 0);
        check("inv_byte_gap", viol_gap, 0);
        check("inv_take_with_start", viol_take, 0);
        check("inv_pulse_owner", viol_own, 0);
        check("inv_error_tied", viol_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Sequences a single shared `spi` engine on behalf of two requesters (for example, CPU register interface and a boot flash loader) and arbitrates between them round-robin. For each granted request it runs a multi-byte burst: it drives the engine's start/busy handshake byte by byte, owns per-requester chip selects and setup/hold gaps, and muxes divisor and data. It sits inside `peripherals`, between the requesters and `spi_0`.

## Interface
- `CS_SETUP`, default 2: cycles of CS asserted before the first byte starts.
- `CS_HOLD`, default 2: cycles of CS held after the last byte completes.
- `TIMEOUT_CYCLES`, default 1024: busy-assert watchdog limit; used only with `SPI_ARB_TIMEOUT_EN`.
- `raw_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  2  per-requester request level.
- `len0`, `len1`  in  8 each  burst byte count; 0 means 256.
- `div0`, `div1`  in  3 each  SPI divisor per requester.
- `tx_byte0`, `tx_byte1`  in  8 each  next byte to send.
- `tx_take`  out  2  one-cycle pulse when `tx_byteN` is consumed; the requester presents the next byte by the following cycle.
- `rx_byte`  out  8  last received byte.
- `rx_valid`  out  2  one-cycle pulse, per requester, when `rx_byte` is valid.
- `grant`  out  2  one-hot owner, or 00.
- `done`  out  2  one-cycle burst-complete pulse.
- `error`  out  2  one-cycle timeout pulse.
- `cs_n`  out  2  per-requester chip select, active-low.
- `spi_start`  out  1  to engine.
- `spi_data_tx`  out  8  to engine.
- `spi_divisor`  out  3  to engine.
- `spi_busy`  in  1  from engine.
- `spi_data_rx`  in  8  from engine.

## Operation
- States: IDLE, SETUP, START, WAIT_BUSY, WAIT_DONE, HOLD.
- **IDLE:** leave when `req != 0` and `spi_busy == 0`.
  - If both requesters are asserted, grant the one not granted last. `last` resets to 1, so requester 0 wins first.
  - On grant: latch the owner, latch `len` into a 9-bit `remaining` (0 → 256), set `grant`, drive `cs_n[owner]` low, go to SETUP.
- **SETUP:** count `CS_SETUP` cycles, then go to START.
- **START:**
  - Register `spi_data_tx <= tx_byteN`.
  - Set `spi_start = 1`.
  - Pulse `tx_take[owner]`.
  - Go to WAIT_BUSY.
- **WAIT_BUSY:** hold `spi_start` until `spi_busy == 1`, then clear `spi_start` and go to WAIT_DONE.
- **WAIT_DONE:** on `spi_busy == 0`:
  - Register `rx_byte <= spi_data_rx` and pulse `rx_valid[owner]`.
  - Decrement `remaining`.
  - If the result is nonzero, go to START; otherwise go to HOLD.
- **HOLD:** count `CS_HOLD` cycles with CS still low. Then:
  - Set `cs_n` to 11.
  - Pulse `done[owner]`.
  - Clear `grant`, update `last`, go to IDLE.
- `spi_divisor` is `div[owner]` while granted and holds its last value in IDLE.
- `req` changes during a burst are ignored; the burst always runs to completion. `req` still high in IDLE counts as a new request.
- At most one `cs_n` bit is low at any time.

## Timing
- Reset values:
  - `grant = 00`, `cs_n = 11`.
  - `spi_start = 0`, `spi_data_tx = 0`, `spi_divisor = 0`.
  - `rx_byte = 0`, `rx_valid = tx_take = done = error = 00`.
  - State IDLE, `last = 1`.
- Reset mid-burst aborts immediately: CS is released the next cycle and no `done` is pulsed. If the engine is still busy, IDLE waits for `spi_busy == 0` before granting again.
- Request-to-CS-low latency: 1 cycle. CS-low to first `spi_start`: `CS_SETUP` + 1 cycles.
- Inter-byte gap: `spi_busy` fall → `rx_valid` next cycle → `spi_start` the cycle after.
- Last `rx_valid` to CS high: `CS_HOLD` + 1 cycles; `done` is asserted in the same cycle CS goes high.
- `len == 0` yields 256 bytes; the counter never wraps below 0.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined: a 16-bit counter runs in WAIT_BUSY. When it reaches `TIMEOUT_CYCLES`, the block:
  - clears `spi_start`;
  - pulses `error[owner]`;
  - goes to HOLD, which then pulses `done` normally.
- Not defined: WAIT_BUSY waits indefinitely, `error` is tied to 00, and no counter is synthesized.

## Structure
- Package `spi_arbiter_pkg`: state enum, default `CS_SETUP`/`CS_HOLD`/`TIMEOUT_CYCLES` constants, `LEN_W = 9`.
- Sub-module `rr_arbiter2`: 2-way round-robin pick from `req` and `last`, producing a one-hot grant. Combinational; `last` is registered in `spi_arbiter`.

## Test plan
- Single burst: `req = 01`, `len0 = 3`, bytes A1/A2/A3, engine model loops back.
  - Required: `cs_n[0]` low for the entire burst, exactly 3 `tx_take[0]` and 3 `rx_valid[0]` with A1/A2/A3, one `done[0]`, `cs_n = 11` afterwards.
- Contention: `req = 11` held, `len = 1`.
  - Required: grants alternate 01, 10, 01…, and both `cs_n` bits are never low together.
- `len0 = 0`.
  - Required: exactly 256 `rx_valid[0]` pulses, then `done[0]`.
- Reset asserted in WAIT_DONE while the engine is still busy.
  - Required: `cs_n = 11` and `grant = 00` the next cycle, no `done`, and no new grant until `spi_busy` falls.
- With `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES = 8`, engine `busy` stuck at 0.
  - Required: `spi_start` clears after 8 cycles, `error[0]` pulses, then `done[0]` after `CS_HOLD`.
- Divisor mux: `div0 = 2`, `div1 = 5`.
  - Required: `spi_divisor` is 2 during requester 0's burst and 5 during requester 1's burst.
